// File: rtl/bictr_tercnt_monitor.sv
// Purpose: measures the cycle period between qualified terminal-count events of an up/down counter and captures its value.
// Latency: results (period, cap_count, rdy, evt_cnt, hit) are registered one edge after the qualifying evt.
// Backpressure: rdy holds until ack; a new result while rdy is pending overwrites it and sets sticky ovr.
module bictr_tercnt_monitor #(
    parameter int width  = 4,
    parameter int pwidth = 16,
    parameter int ewidth = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cen,
    input  logic              tercnt,
    input  logic [width-1:0]  count,
    input  logic              clr,
    input  logic [ewidth-1:0] thresh,
    input  logic              ack,
    output logic [pwidth-1:0] period,
    output logic [width-1:0]  cap_count,
    output logic              rdy,
    output logic              ovr,
    output logic [ewidth-1:0] evt_cnt,
    output logic              hit
);

    typedef enum logic {
        ST_ARM = 1'b0,
        ST_RUN = 1'b1
    } state_t;

    localparam logic [pwidth-1:0] TIMER_MAX = '1;
    localparam logic [ewidth-1:0] EVT_MAX   = '1;

    state_t              state_q,     state_d;
    logic [pwidth-1:0]   timer_q,     timer_d;
    logic [pwidth-1:0]   period_q,    period_d;
    logic [width-1:0]    cap_count_q, cap_count_d;
    logic                rdy_q,       rdy_d;
    logic                ovr_q,       ovr_d;
    logic [ewidth-1:0]   evt_cnt_q,   evt_cnt_d;
    logic                hit_q,       hit_d;

    logic                evt;
    logic [pwidth-1:0]   timer_inc;

    // Qualified event and the saturating timer increment; the same value is
    // the next timer value and the period to publish, since the edge that
    // sees the event also counts as one elapsed cycle.
    always_comb begin
        evt       = tercnt & cen;
        timer_inc = (timer_q == TIMER_MAX) ? TIMER_MAX : timer_q + 1'b1;
    end

    // Next-state logic: clr dominates, otherwise ARM waits for the first
    // event and RUN measures the gap to each following event.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        period_d    = period_q;
        cap_count_d = cap_count_q;
        rdy_d       = rdy_q;
        ovr_d       = ovr_q;
        evt_cnt_d   = evt_cnt_q;
        hit_d       = 1'b0;

        if (clr) begin
            state_d     = ST_ARM;
            timer_d     = '0;
            period_d    = '0;
            cap_count_d = '0;
            rdy_d       = 1'b0;
            ovr_d       = 1'b0;
            evt_cnt_d   = '0;
        end else begin
            // Event counter saturates; hit only fires on an actual change,
            // so a stuck-at-max counter cannot pulse again.
            if (evt && (evt_cnt_q != EVT_MAX)) begin
                evt_cnt_d = evt_cnt_q + 1'b1;
                hit_d     = (thresh != '0) && (evt_cnt_d == thresh);
            end

            // Consumer handshake; ack without a pending result is ignored.
            if (ack && rdy_q) begin
                rdy_d = 1'b0;
            end

            case (state_q)
                ST_ARM: begin
                    timer_d = '0;
                    if (evt) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (evt) begin
                        period_d    = timer_inc;
                        cap_count_d = count;
                        timer_d     = '0;
                        rdy_d       = 1'b1;
                        // Overrun only when the old result was never consumed.
                        if (rdy_q && !ack) begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        timer_d = timer_inc;
                    end
                end
                default: begin
                    state_d = ST_ARM;
                    timer_d = '0;
                end
            endcase
        end
    end

    // State and registered outputs; reset assertion takes effect immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_ARM;
            timer_q     <= '0;
            period_q    <= '0;
            cap_count_q <= '0;
            rdy_q       <= 1'b0;
            ovr_q       <= 1'b0;
            evt_cnt_q   <= '0;
            hit_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            period_q    <= period_d;
            cap_count_q <= cap_count_d;
            rdy_q       <= rdy_d;
            ovr_q       <= ovr_d;
            evt_cnt_q   <= evt_cnt_d;
            hit_q       <= hit_d;
        end
    end

    assign period    = period_q;
    assign cap_count = cap_count_q;
    assign rdy       = rdy_q;
    assign ovr       = ovr_q;
    assign evt_cnt   = evt_cnt_q;
    assign hit       = hit_q;

endmodule
